// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word adder sequencer: the default chunk geometry
// and the FSM state encoding used by the top level and its debug port.
package adder_pkg;

    localparam int W_DEFAULT = 4;
    localparam int K_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-chunk operand still needs a one-bit index register.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Operand/result bus of the multi-word adder sequencer. The sub signal exists only
// when MULTIWORD_ADD_SEQUENCER_SUB_EN is defined.
interface multiword_add_sequencer_if #(
    parameter int W = adder_pkg::W_DEFAULT,
    parameter int K = adder_pkg::K_DEFAULT
);
    localparam int OW = W * K;

    // Handshake: an operand pair transfers on a rising clk edge where in_valid & in_ready
    // are both high; a result transfers on a rising edge where out_valid & out_ready are
    // both high. Neither ready depends combinationally on its valid, and a raised valid
    // with its payload is held by the sender until the transfer edge.
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] A;
    logic [OW-1:0] B;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    logic          sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [OW:0]   total;
    logic          busy;

    modport master (
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        output sub,
`endif
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, total, busy
    );

    modport slave (
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        input  sub,
`endif
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, total, busy
    );

endinterface

// File: rtl/chunk_adder_cin.sv
// Combinational W-bit ripple adder with carry-in, one full-adder cell per bit.
module chunk_adder_cin #(
    parameter int W = 4
) (
    output logic         cout,
    output logic [W-1:0] sum,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin
);
    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        fa_cell u_fa (
            .cout (c[i+1]),
            .s    (sum[i]),
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i])
        );
    end

    assign cout = c[W];
endmodule

// File: rtl/fa_cell.sv
// Full-adder cell built from two half-adder cells.
module fa_cell (
    output logic cout,
    output logic s,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic s1;
    logic c1;
    logic c2;

    ha_cell u_ha0 (.c(c1), .s(s1), .a(a),  .b(b));
    ha_cell u_ha1 (.c(c2), .s(s),  .a(s1), .b(cin));

    // The two half-adder carries can never both be high.
    assign cout = c1 | c2;
endmodule

// File: rtl/ha_cell.sv
// Half-adder cell: one-bit sum and carry of two inputs.
module ha_cell (
    output logic c,
    output logic s,
    input  logic a,
    input  logic b
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-word adder: walks K chunks of W bits through one shared W-bit adder, one chunk per
// cycle, result after exactly K cycles. Define MULTIWORD_ADD_SEQUENCER_SUB_EN for A-B mode.
module multiword_add_sequencer
    import adder_pkg::*;
#(
    parameter int W = W_DEFAULT,
    parameter int K = K_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    multiword_add_sequencer_if.slave bus,
    output state_e                   state_dbg
);

    localparam int OW   = W * K;
    localparam int IDXW = idx_width(K);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            c_q, c_d;
    logic [OW-1:0]   a_q, a_d;
    logic [OW-1:0]   b_q, b_d;
    logic [OW-1:0]   res_q, res_d;
    logic [OW:0]     total_q, total_d;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    logic            sub_q, sub_d;
`endif

    logic [W-1:0]    a_chunk;
    logic [W-1:0]    b_chunk;
    logic [W-1:0]    b_eff;
    logic [W-1:0]    sum_chunk;
    logic            cout_chunk;

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < K; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[i*W +: W];
                b_chunk = b_q[i*W +: W];
            end
        end
    end

`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
    // A - B computed as A + ~B + 1; the +1 enters as the initial carry.
    assign b_eff = sub_q ? ~b_chunk : b_chunk;
`else
    assign b_eff = b_chunk;
`endif

    chunk_adder_cin #(.W(W)) u_adder (
        .cout (cout_chunk),
        .sum  (sum_chunk),
        .a    (a_chunk),
        .b    (b_eff),
        .cin  (c_q)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        c_d     = c_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        total_d = total_q;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    idx_d   = '0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
                    sub_d   = bus.sub;
                    c_d     = bus.sub;
`else
                    c_d     = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < K; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        res_d[i*W +: W] = sum_chunk;
                    end
                end
                c_d   = cout_chunk;
                idx_d = idx_q + IDXW'(1);
                // The final chunk's carry-out is the top bit of the published total.
                if (idx_q == IDXW'(K - 1)) begin
                    total_d = {cout_chunk, res_d};
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            c_q     <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            total_q <= '0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            c_q     <= c_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            total_q <= total_d;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.total     = total_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: a W=4/K=4 instance checked every cycle against a
// transaction-level model, plus a W=8/K=1 instance exercised with directed vectors.
module tb_multiword_add_sequencer;
    import adder_pkg::*;

    localparam int W  = 4;
    localparam int K  = 4;
    localparam int OW = W * K;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multiword_add_sequencer_if #(.W(W), .K(K)) bus ();
    multiword_add_sequencer_if #(.W(8), .K(1)) bus1 ();
    state_e state_dbg;
    state_e state_dbg1;

    multiword_add_sequencer #(.W(W), .K(K)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    multiword_add_sequencer #(.W(8), .K(1)) u_dut_k1 (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus1),
        .state_dbg (state_dbg1)
    );

    int total_cnt = 0;
    int bad_cnt   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    logic [OW:0] exp_q[$];
    logic        drv_sub = 1'b0;
    int          m_left  = 0;
    bit          m_done  = 1'b0;
    logic [OW:0] m_total = '0;
    bit          started = 1'b0;

    function automatic logic [OW:0] model_total(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                                input logic s);
        // A - B + 2^OW: top bit is 1 exactly when no borrow occurs.
        if (s) return {1'b0, a} + {1'b0, ~b} + (OW+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        if (reset) begin
            m_left  = 0;
            m_done  = 1'b0;
            m_total = '0;
            exp_q.delete();
        end else if (m_done) begin
            if (bus.out_ready) m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1'b1;
                if (exp_q.size() > 0) m_total = exp_q.pop_front();
            end
        end else if (bus.in_valid) begin
            exp_q.push_back(model_total(bus.A, bus.B, drv_sub));
            m_left = K;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cyc_in_ready",  bus.in_ready,  (m_left == 0 && !m_done));
            check("cyc_busy",      bus.busy,      (m_left > 0));
            check("cyc_out_valid", bus.out_valid, m_done);
            check("cyc_total",     bus.total,     m_total);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic s,
                        output int waits);
        waits = 0;
        bus.in_valid = 1'b1;
        bus.A = a;
        bus.B = b;
        drv_sub = s;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        bus.sub = s;
`endif
        while (!bus.in_ready && waits < 50) begin
            tick();
            waits++;
        end
        check("accept_timeout", (waits < 50), 1);
        tick();
        // Scramble the operand lines: the accepted pair must already be captured.
        bus.in_valid = 1'b0;
        bus.A = OW'($urandom);
        bus.B = OW'($urandom);
        drv_sub = 1'($urandom_range(0, 1));
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        bus.sub = drv_sub;
`endif
    endtask

    task automatic receive(input int hold, input logic [OW:0] exp, output int lat,
                           output int busy_n);
        lat    = 0;
        busy_n = bus.busy ? 1 : 0;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
            if (bus.busy) busy_n++;
        end
        check("out_valid_timeout", bus.out_valid, 1);
        check("result_total", bus.total, exp);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_total",     bus.total,     exp);
            check("hold_in_ready",  bus.in_ready,  0);
            check("hold_out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic          s;
        logic [OW:0]   exp;
    } vec_t;

    vec_t vecs[$];

    // ---------------- directed sequence ----------------
    initial begin
        int waits;
        int lat;
        int busy_n;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        bus1.A         = '0;
        bus1.B         = '0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        bus.sub  = 1'b0;
        bus1.sub = 1'b0;
`endif

        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 17'h1_0000});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 17'h0_5555});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 17'h1_FFFE});
        vecs.push_back('{16'hA5A5, 16'h5A5A, 1'b0, 17'h0_FFFF});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 17'h0_0000});
        vecs.push_back('{16'h00F8, 16'h0F08, 1'b0, 17'h0_1000});
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 17'h0_FFFE});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 17'h1_0002});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 17'h1_0000});
`endif

        repeat (3) tick();
        reset = 1'b0;

        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy",      bus.busy,      0);
        check("rst_total",     bus.total,     0);
        check("rst_state",     state_dbg,     IDLE);
        check("rst_k1_ready",  bus1.in_ready, 1);
        check("rst_k1_total",  bus1.total,    0);

        foreach (vecs[i]) begin
            send(vecs[i].a, vecs[i].b, vecs[i].s, waits);
            receive(0, vecs[i].exp, lat, busy_n);
            check("latency", lat, 4);
            check("busy_cycles", busy_n, 4);
        end

        // Backpressure, with the next pair already offered while the result waits.
        send(16'h8000, 16'h8000, 1'b0, waits);
        bus.in_valid = 1'b1;
        bus.A = 16'h0F0F;
        bus.B = 16'h00F1;
        drv_sub = 1'b0;
`ifdef MULTIWORD_ADD_SEQUENCER_SUB_EN
        bus.sub = 1'b0;
`endif
        receive(5, 17'h1_0000, lat, busy_n);
        check("bp_ready_after_pulse", bus.in_ready, 1);
        send(16'h0F0F, 16'h00F1, 1'b0, waits);
        check("bp_accept_wait", waits, 0);
        receive(0, 17'h0_1000, lat, busy_n);
        check("bp_latency", lat, 4);

        // Reset while the chunk at index 2 is being processed.
        send(16'hFFFF, 16'h0001, 1'b0, waits);
        tick();
        tick();
        check("mid_busy", bus.busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_in_ready",  bus.in_ready,  1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy",      bus.busy,      0);
        check("mid_rst_total",     bus.total,     0);
        send(16'h0001, 16'h0001, 1'b0, waits);
        receive(0, 17'h0_0002, lat, busy_n);
        check("post_rst_latency", lat, 4);

        // Single-chunk instance.
        bus1.in_valid = 1'b1;
        bus1.A = 8'hFF;
        bus1.B = 8'h01;
        tick();
        bus1.in_valid = 1'b0;
        bus1.A = 8'h55;
        bus1.B = 8'h55;
        check("k1_busy",      bus1.busy,      1);
        check("k1_out_valid", bus1.out_valid, 0);
        tick();
        check("k1_done_valid", bus1.out_valid, 1);
        check("k1_total",      bus1.total,     9'h100);
        check("k1_done_busy",  bus1.busy,      0);
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check("k1_back_ready", bus1.in_ready, 1);
        check("k1_hold_total", bus1.total,    9'h100);

        repeat (2) tick();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

    initial begin
        #200000;
        bad_cnt++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $fatal(1, "watchdog");
    end

endmodule
